esc_pwm_decoder: RTL and testbench



---
 rtl/esc_pwm_decoder.sv | 217 +++++++++++++++++++++
 tb/tb_esc_pwm_decoder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/esc_pwm_decoder.sv
// esc_pwm_decoder
// Measures the high time of an ESC-style PWM pulse and recovers the 11-bit
// SPEED command that produced it. The relationship is H = OFFSET + 3*SPEED.
// A good pulse gives a one-cycle vld strobe together with the new SPEED.
// A pulse that is too short or too long gives a one-cycle err strobe, and
// SPEED holds its last value.
//
// Ports:
//   clk     system clock
//   rst     synchronous, active-high reset
//   PWM_in  asynchronous PWM input (2-flop synchronised internally)
//   SPEED   last successfully decoded speed
//   vld     one-cycle strobe, SPEED updated this cycle
//   err     one-cycle strobe, last pulse out of range
//   lost    level, no pulse activity within TIMEOUT_CYC cycles
//
// Optional feature: define ESC_DEC_TIMEOUT_EN to build the loss-of-signal
// watchdog. Without it, lost is tied low and no watchdog logic exists.

module esc_pwm_decoder #(
   parameter int unsigned OFFSET      = 6251,
   parameter int unsigned MAX_SPEED   = 2047,
   parameter int unsigned TIMEOUT_CYC = 1048576
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PWM_in,
   output logic [10:0] SPEED,
   output logic        vld,
   output logic        err,
   output logic        lost
);

   localparam int unsigned CNT_W = (OFFSET > 1) ? $clog2(OFFSET + 1) : 1;
   localparam int unsigned ACC_W = 12;

   typedef enum logic [1:0] {
      S_ARM    = 2'd0,
      S_IDLE   = 2'd1,
      S_OFFSET = 2'd2,
      S_MEAS   = 2'd3
   } state_t;

   state_t state, state_nxt_c;

   logic pwm_m, pwm_s, pwm_d;
   logic rise_c, fall_c;

   logic [CNT_W-1:0] cnt;
   logic [1:0]       presc;
   logic [ACC_W-1:0] acc;
   logic             ovf;
   logic             off_done_c;

   logic cnt_load_c, cnt_inc_c, meas_clr_c, meas_step_c, ok_c, bad_c;

   logic        res_ok_q, res_bad_q;
   logic [10:0] res_spd_q;
   logic        wd_hit_c;

   // Synchroniser plus edge-detect flop. These flops reset high so a pulse
   // already present at reset does not look like a fresh rising edge.
   always_ff @(posedge clk) begin : sync_p
      if (rst) begin
         pwm_m <= 1'b1;
         pwm_s <= 1'b1;
         pwm_d <= 1'b1;
      end else begin
         pwm_m <= PWM_in;
         pwm_s <= pwm_m;
         pwm_d <= pwm_s;
      end
   end

   assign rise_c = pwm_s & ~pwm_d;
   assign fall_c = ~pwm_s & pwm_d;

   // Asserted on the high cycle whose count reaches OFFSET.
   assign off_done_c = (cnt >= CNT_W'(OFFSET - 1));

   // State register
   always_ff @(posedge clk) begin : state_p
      if (rst) state <= S_ARM;
      else     state <= state_nxt_c;
   end

   // Next-state logic
   always_comb begin : next_p
      state_nxt_c = state;
      case (state)
         S_ARM:    if (!pwm_s) state_nxt_c = S_IDLE;
         S_IDLE:   if (rise_c) state_nxt_c = (OFFSET <= 1) ? S_MEAS : S_OFFSET;
         S_OFFSET: begin
            if (fall_c)          state_nxt_c = S_IDLE;
            else if (off_done_c) state_nxt_c = S_MEAS;
         end
         S_MEAS:   if (fall_c) state_nxt_c = S_IDLE;
         default:  state_nxt_c = S_ARM;
      endcase
   end

   // Datapath controls and result decisions
   always_comb begin : out_p
      cnt_load_c  = 1'b0;
      cnt_inc_c   = 1'b0;
      meas_clr_c  = 1'b0;
      meas_step_c = 1'b0;
      ok_c        = 1'b0;
      bad_c       = 1'b0;
      case (state)
         S_IDLE: begin
            if (rise_c) begin
               cnt_load_c = 1'b1;
               meas_clr_c = (OFFSET <= 1);
            end
         end
         S_OFFSET: begin
            if (fall_c) begin
               bad_c = 1'b1;
            end else if (pwm_s) begin
               cnt_inc_c  = 1'b1;
               meas_clr_c = off_done_c;
            end
         end
         S_MEAS: begin
            if (fall_c) begin
               ok_c  = ~ovf;
               bad_c = ovf;
            end else if (pwm_s) begin
               meas_step_c = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Offset counter, mod-3 prescaler and saturating speed accumulator
   always_ff @(posedge clk) begin : meas_p
      if (rst) begin
         cnt       <= '0;
         presc     <= 2'd0;
         acc       <= '0;
         ovf       <= 1'b0;
         res_ok_q  <= 1'b0;
         res_bad_q <= 1'b0;
         res_spd_q <= 11'd0;
      end else begin
         res_ok_q  <= ok_c;
         res_bad_q <= bad_c;
         if (ok_c) res_spd_q <= acc[10:0];

         if (cnt_load_c)
            cnt <= CNT_W'(1);
         else if (cnt_inc_c && (cnt != '1))
            cnt <= cnt + CNT_W'(1);

         if (meas_clr_c) begin
            presc <= 2'd0;
            acc   <= '0;
            ovf   <= 1'b0;
         end else if (meas_step_c) begin
            if (presc == 2'd2) begin
               presc <= 2'd0;
               if (acc != '1) acc <= acc + ACC_W'(1);
               if (acc >= ACC_W'(MAX_SPEED)) ovf <= 1'b1;
            end else begin
               presc <= presc + 2'd1;
            end
         end
      end
   end

   // Output stage. This is the extra registered edge that puts the strobe
   // three edges after the first low input sample.
   always_ff @(posedge clk) begin : outreg_p
      if (rst) begin
         SPEED <= 11'd0;
         vld   <= 1'b0;
         err   <= 1'b0;
      end else begin
         vld <= res_ok_q;
         err <= res_bad_q;
         if (res_ok_q)      SPEED <= res_spd_q;
         else if (wd_hit_c) SPEED <= 11'd0;
      end
   end

`ifdef ESC_DEC_TIMEOUT_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

   logic [WD_W-1:0] wd_cnt;

   // Fires once, on the cycle the counter would reach TIMEOUT_CYC.
   assign wd_hit_c = ~rise_c & ~res_ok_q & (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

   // Watchdog. A good decode also restarts it, so a pulse longer than the
   // timeout does not leave the counter parked at its limit.
   always_ff @(posedge clk) begin : wd_p
      if (rst) begin
         wd_cnt <= '0;
         lost   <= 1'b0;
      end else begin
         if (rise_c || res_ok_q)
            wd_cnt <= '0;
         else if (wd_cnt != WD_W'(TIMEOUT_CYC))
            wd_cnt <= wd_cnt + WD_W'(1);

         if (res_ok_q)      lost <= 1'b0;
         else if (wd_hit_c) lost <= 1'b1;
      end
   end
`else
   assign wd_hit_c = 1'b0;
   assign lost     = 1'b0;
`endif

endmodule

// File: tb/tb_esc_pwm_decoder.sv
// Directed testbench for esc_pwm_decoder. It checks the decode values, the
// strobe latency, the error cases, reset behaviour and the optional watchdog.
module tb_esc_pwm_decoder;

   localparam int unsigned OFFSET    = 6251;
   localparam int unsigned MAX_SPEED = 2047;
`ifdef ESC_DEC_TIMEOUT_EN
   localparam int unsigned TIMEOUT   = 1000;
   // Long pulses trip the watchdog mid-pulse, which zeroes the held SPEED.
   localparam logic [10:0] HOLD_SPD  = 11'd0;
`else
   localparam int unsigned TIMEOUT   = 1048576;
   localparam logic [10:0] HOLD_SPD  = 11'd2047;
`endif

   logic        clk;
   logic        rst;
   logic        PWM_in;
   logic [10:0] SPEED;
   logic        vld;
   logic        err;
   logic        lost;

   int checks;
   int errors;
   int vld_cnt;
   int err_cnt;

   esc_pwm_decoder #(
      .OFFSET      (OFFSET),
      .MAX_SPEED   (MAX_SPEED),
      .TIMEOUT_CYC (TIMEOUT)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .PWM_in (PWM_in),
      .SPEED  (SPEED),
      .vld    (vld),
      .err    (err),
      .lost   (lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count the strobes so that a stray strobe anywhere can be detected.
   always @(negedge clk) begin
      if (vld) vld_cnt++;
      if (err) err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Drive one pulse whose high time is h input samples, preceded by a short
   // low gap. The strobe must be absent after F+2 and present after F+3,
   // where F is the first low sample, and it must last exactly one cycle.
   task automatic pulse(input string tag, input int h, input logic exp_ok,
                        input logic exp_bad, input logic [10:0] exp_spd);
      repeat (4) @(posedge clk);
      #1 PWM_in = 1'b1;
      repeat (h) @(posedge clk);
      #1 PWM_in = 1'b0;
      repeat (3) @(posedge clk);
      #1 check({tag, "_early"}, 32'({vld, err}), 32'd0);
      @(posedge clk);
      #1;
      check({tag, "_vld"}, 32'(vld), 32'(exp_ok));
      check({tag, "_err"}, 32'(err), 32'(exp_bad));
      check({tag, "_speed"}, 32'(SPEED), 32'(exp_spd));
      @(posedge clk);
      #1 check({tag, "_onecyc"}, 32'({vld, err}), 32'd0);
   endtask

   initial begin
      int v0;
      int e0;
      checks  = 0;
      errors  = 0;
      vld_cnt = 0;
      err_cnt = 0;
      rst     = 1'b1;
      PWM_in  = 1'b1;

      // Reset values, with the input already high
      repeat (3) @(posedge clk);
      #1;
      check("rst_speed", 32'(SPEED), 32'd0);
      check("rst_vld",   32'(vld),   32'd0);
      check("rst_err",   32'(err),   32'd0);
      check("rst_lost",  32'(lost),  32'd0);
      rst = 1'b0;

      // A pulse that is high through reset is never decoded
      repeat (8000) @(posedge clk);
      #1 PWM_in = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("arm_vld_cnt", 32'(vld_cnt), 32'd0);
      check("arm_err_cnt", 32'(err_cnt), 32'd0);
      check("arm_speed",   32'(SPEED),   32'd0);

      pulse("h6251", 6251, 1'b1, 1'b0, 11'd0);
      check("h6251_lost", 32'(lost), 32'd0);
      pulse("h9320", 9320, 1'b1, 1'b0, 11'd1023);
      pulse("h9322", 9322, 1'b1, 1'b0, 11'd1023);
      pulse("h12392", 12392, 1'b1, 1'b0, 11'd2047);
      check("h12392_lost", 32'(lost), 32'd0);
      pulse("h12395", 12395, 1'b0, 1'b1, HOLD_SPD);
      pulse("h6250", 6250, 1'b0, 1'b1, HOLD_SPD);

      // Reset partway through an 8000-cycle pulse aborts it without a strobe
      v0 = vld_cnt;
      e0 = err_cnt;
      repeat (4) @(posedge clk);
      #1 PWM_in = 1'b1;
      repeat (7000) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (999) @(posedge clk);
      #1 PWM_in = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("mid_rst_vld_cnt", 32'(vld_cnt), 32'(v0));
      check("mid_rst_err_cnt", 32'(err_cnt), 32'(e0));
      check("mid_rst_speed",   32'(SPEED),   32'd0);
      pulse("h6254", 6254, 1'b1, 1'b0, 11'd1);
      check("h6254_lost", 32'(lost), 32'd0);

`ifdef ESC_DEC_TIMEOUT_EN
      // Watchdog: 1000 idle cycles after a good decode raise lost
      pulse("h7751", 7751, 1'b1, 1'b0, 11'd500);
      check("wd_lost_after_vld", 32'(lost), 32'd0);
      repeat (998) @(posedge clk);
      #1 check("wd_lost_before", 32'(lost), 32'd0);
      @(posedge clk);
      #1;
      check("wd_lost_set",   32'(lost),  32'd1);
      check("wd_speed_zero", 32'(SPEED), 32'd0);
      pulse("wd_h6251", 6251, 1'b1, 1'b0, 11'd0);
      check("wd_lost_clear", 32'(lost), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
